// File: rtl/alu_74382_slice_seq.sv
// alu_74382_slice_seq: runs one WORD_W-wide operation as NUM_SLICES
// least-significant-first passes through an external 74382-style ALU slice.
// The carry is chained between slices through a register.
// Optional: define ALU_74382_SLICE_SEQ_ZERO_EN to add the rsp_zero flag output.

package alu_74382_pkg;
  localparam int SELECT_W = 3;
  localparam logic [SELECT_W-1:0] OP_CLEAR   = 3'd0;
  localparam logic [SELECT_W-1:0] OP_B_SUB_A = 3'd1;
  localparam logic [SELECT_W-1:0] OP_A_SUB_B = 3'd2;
  localparam logic [SELECT_W-1:0] OP_ADD     = 3'd3;
  localparam logic [SELECT_W-1:0] OP_XOR     = 3'd4;
  localparam logic [SELECT_W-1:0] OP_OR      = 3'd5;
  localparam logic [SELECT_W-1:0] OP_AND     = 3'd6;
  localparam logic [SELECT_W-1:0] OP_PRESET  = 3'd7;
endpackage

module alu_74382_slice_seq
  import alu_74382_pkg::*;
#(
  parameter int SLICE_W    = 4,
  parameter int NUM_SLICES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [SELECT_W-1:0]              req_sel,
  input  logic                             req_cin,
  input  logic [SLICE_W*NUM_SLICES-1:0]    req_a,
  input  logic [SLICE_W*NUM_SLICES-1:0]    req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [SLICE_W*NUM_SLICES-1:0]    rsp_result,
  output logic                             rsp_cout,
  output logic                             rsp_ovf,
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
  output logic                             rsp_zero,
`endif
  output logic [SELECT_W-1:0]              alu_sel,
  output logic                             alu_carry_in,
  output logic [SLICE_W-1:0]               alu_port_a,
  output logic [SLICE_W-1:0]               alu_port_b,
  input  logic [SLICE_W-1:0]               alu_result,
  input  logic                             alu_carry_out,
  input  logic                             alu_overflow,
  output logic                             busy
);

  localparam int WORD_W = SLICE_W * NUM_SLICES;
  localparam int IDX_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [SELECT_W-1:0] r_sel;
  logic [WORD_W-1:0]   r_a;
  logic [WORD_W-1:0]   r_b;
  logic [WORD_W-1:0]   r_res;
  logic                r_cout;
  logic                r_ovf;
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
  logic                r_zero;
`endif

  logic [SLICE_W-1:0]  w_a_slice [NUM_SLICES];
  logic [SLICE_W-1:0]  w_b_slice [NUM_SLICES];
  logic [WORD_W-1:0]   w_res_merged;
  logic                w_accept;
  logic                w_run;
  logic                w_last;

  // Per-slice operand views and the result word with the current ALU output
  // merged into the active slice (used both for res update and zero flag).
  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign w_a_slice[gi] = r_a[gi*SLICE_W +: SLICE_W];
      assign w_b_slice[gi] = r_b[gi*SLICE_W +: SLICE_W];
      assign w_res_merged[gi*SLICE_W +: SLICE_W] =
        (r_idx == IDX_W'(gi)) ? alu_result : r_res[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign w_last = (r_idx == IDX_W'(NUM_SLICES - 1));

  // ALU inputs come straight from registers so they stay stable outside RUN.
  assign alu_sel      = r_sel;
  assign alu_carry_in = r_carry;
  assign alu_port_a   = w_a_slice[r_idx];
  assign alu_port_b   = w_b_slice[r_idx];

  assign rsp_result = r_res;
  assign rsp_cout   = r_cout;
  assign rsp_ovf    = r_ovf;
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
  assign rsp_zero   = r_zero;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture request, then one slice per cycle with carry chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sel   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
      r_zero  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sel   <= req_sel;
      r_a     <= req_a;
      r_b     <= req_b;
      r_carry <= req_cin;
      r_idx   <= '0;
      r_res   <= '0;
    end else if (w_run) begin
      r_res   <= w_res_merged;
      r_carry <= alu_carry_out;
      if (w_last) begin
        r_cout <= alu_carry_out;
        r_ovf  <= alu_overflow;
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
        r_zero <= (w_res_merged == '0);
`endif
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_74382_slice_seq.sv
// Testbench for alu_74382_slice_seq with a behavioural 74382 slice stand-in
// and a word-level reference model.
module tb_alu_74382_slice_seq;
  import alu_74382_pkg::*;

  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = 4;
  localparam int WORD_W     = SLICE_W * NUM_SLICES;

  logic                clk;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [SELECT_W-1:0] req_sel;
  logic                req_cin;
  logic [WORD_W-1:0]   req_a;
  logic [WORD_W-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORD_W-1:0]   rsp_result;
  logic                rsp_cout;
  logic                rsp_ovf;
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
  logic                rsp_zero;
`endif
  logic [SELECT_W-1:0] alu_sel;
  logic                alu_carry_in;
  logic [SLICE_W-1:0]  alu_port_a;
  logic [SLICE_W-1:0]  alu_port_b;
  logic [SLICE_W-1:0]  alu_result;
  logic                alu_carry_out;
  logic                alu_overflow;
  logic                busy;

  int checks = 0;
  int errors = 0;

  alu_74382_slice_seq #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
    .rsp_zero(rsp_zero),
`endif
    .alu_sel(alu_sel), .alu_carry_in(alu_carry_in),
    .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_overflow(alu_overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the 74382 slice: arithmetic ops produce carry/overflow,
  // logic ops and CLEAR/PRESET report carry and overflow as 0.
  always_comb begin
    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W:0]   s;
    logic               arith;
    x = alu_port_a;
    y = alu_port_b;
    s = '0;
    arith = 1'b0;
    alu_result    = '0;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_sel)
      OP_ADD:     begin arith = 1'b1; end
      OP_A_SUB_B: begin arith = 1'b1; y = ~alu_port_b; end
      OP_B_SUB_A: begin arith = 1'b1; x = alu_port_b; y = ~alu_port_a; end
      OP_XOR:     alu_result = alu_port_a ^ alu_port_b;
      OP_OR:      alu_result = alu_port_a | alu_port_b;
      OP_AND:     alu_result = alu_port_a & alu_port_b;
      OP_PRESET:  alu_result = '1;
      default:    alu_result = '0;
    endcase
    if (arith) begin
      s = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, alu_carry_in};
      alu_result    = s[SLICE_W-1:0];
      alu_carry_out = s[SLICE_W];
      alu_overflow  = (x[SLICE_W-1] == y[SLICE_W-1]) && (s[SLICE_W-1] != x[SLICE_W-1]);
    end
  end

  // Word-level reference: unsigned sum for carry, signed sum range for overflow.
  function automatic void ref_op(input logic [SELECT_W-1:0] sel, input logic cin,
                                 input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                 output logic [WORD_W-1:0] r, output logic co, output logic ov);
    int unsigned ua, ub, us;
    int          sa, sb, ss;
    logic [WORD_W-1:0] na, nb;
    bit arith;
    na = ~a;
    nb = ~b;
    ua = 32'(a);
    ub = 32'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; co = 1'b0; ov = 1'b0; arith = 1'b0;
    case (sel)
      OP_ADD:     arith = 1'b1;
      OP_A_SUB_B: begin arith = 1'b1; ub = 32'(nb); sb = -sb - 1; end
      OP_B_SUB_A: begin arith = 1'b1; ua = 32'(b); sa = int'($signed(b));
                        ub = 32'(na); sb = -int'($signed(a)) - 1; end
      OP_XOR:     r = a ^ b;
      OP_OR:      r = a | b;
      OP_AND:     r = a & b;
      OP_PRESET:  r = '1;
      default:    r = '0;
    endcase
    if (arith) begin
      us = ua + ub + 32'(cin);
      ss = sa + sb + int'(cin);
      r  = us[WORD_W-1:0];
      co = (us > 32'(16'hFFFF));
      ov = (ss > 32767) || (ss < -32768);
    end
  endfunction

  // Issues one request from IDLE, checks slice sequencing, latency and the
  // response against the reference, then completes the response handshake.
  task automatic run_op(input logic [SELECT_W-1:0] sel, input logic cin,
                        input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                        input int hold, output logic [WORD_W-1:0] r_o,
                        output logic co_o, output logic ov_o);
    logic [WORD_W-1:0] er;
    logic ec, eo;
    logic [SLICE_W-1:0] ea;
    int cyc;
    ref_op(sel, cin, a, b, er, ec, eo);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    req_sel = sel; req_cin = cin; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      if (cyc < NUM_SLICES) begin
        ea = a[cyc*SLICE_W +: SLICE_W];
        checks++;
        if (alu_port_a !== ea || alu_sel !== sel) begin
          errors++;
          $display("FAIL alu_drive slice %0d: got a=%h sel=%0d expected a=%h sel=%0d",
                   cyc, alu_port_a, alu_sel, ea, sel);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != NUM_SLICES) begin
      errors++; $display("FAIL latency: got %0d expected %0d", cyc, NUM_SLICES);
    end
    repeat (hold) begin @(posedge clk); #1; end
    checks++;
    if (rsp_result !== er || rsp_cout !== ec || rsp_ovf !== eo || busy !== 1'b1) begin
      errors++;
      $display("FAIL response: got r=%h c=%b o=%b busy=%b expected r=%h c=%b o=%b busy=1",
               rsp_result, rsp_cout, rsp_ovf, busy, er, ec, eo);
    end
`ifdef ALU_74382_SLICE_SEQ_ZERO_EN
    checks++;
    if (rsp_zero !== (er == '0)) begin
      errors++; $display("FAIL zero_flag: got %b expected %b", rsp_zero, (er == '0));
    end
`endif
    r_o = rsp_result; co_o = rsp_cout; ov_o = rsp_ovf;
    $display("op sel=%0d cin=%0b a=%h b=%h -> res=%h cout=%b ovf=%b lat=%0d",
             sel, cin, a, b, rsp_result, rsp_cout, rsp_ovf, cyc);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: got valid=%b ready=%b expected valid=0 ready=1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_result !== '0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b r=%h c=%b o=%b expected 1 0 0 0000 0 0",
               req_ready, rsp_valid, busy, rsp_result, rsp_cout, rsp_ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [SELECT_W-1:0] sel;
    logic                cin;
    logic [WORD_W-1:0]   a;
    logic [WORD_W-1:0]   b;
    logic [WORD_W-1:0]   er;
    logic                ec;
    logic                eo;
  } vec_t;

  task automatic test_directed();
    vec_t v [9];
    logic [WORD_W-1:0] r;
    logic c, o;
    v[0] = '{OP_ADD,     1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    v[1] = '{OP_ADD,     1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    v[2] = '{OP_ADD,     1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    v[3] = '{OP_A_SUB_B, 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
    v[4] = '{OP_A_SUB_B, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    v[5] = '{OP_XOR,     1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0};
    v[6] = '{OP_PRESET,  1'b0, 16'h1234, 16'h5678, 16'hFFFF, 1'b0, 1'b0};
    v[7] = '{OP_CLEAR,   1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0};
    v[8] = '{OP_B_SUB_A, 1'b1, 16'h0001, 16'h0005, 16'h0004, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].sel, v[i].cin, v[i].a, v[i].b, 0, r, c, o);
      checks++;
      if (r !== v[i].er || c !== v[i].ec || o !== v[i].eo) begin
        errors++;
        $display("FAIL directed[%0d]: got r=%h c=%b o=%b expected r=%h c=%b o=%b",
                 i, r, c, o, v[i].er, v[i].ec, v[i].eo);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WORD_W-1:0] er1, er2, r;
    logic ec, eo, c, o;
    int cyc;
    ref_op(OP_ADD, 1'b0, 16'h0102, 16'h0304, er1, ec, eo);
    ref_op(OP_AND, 1'b0, 16'hF0F0, 16'h3C3C, er2, ec, eo);
    req_sel = OP_ADD; req_cin = 1'b0; req_a = 16'h0102; req_b = 16'h0304; req_valid = 1'b1;
    @(posedge clk); #1;
    req_sel = OP_AND; req_a = 16'hF0F0; req_b = 16'h3C3C;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== er1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got vld=%b r=%h rdy=%b expected 1 %h 0",
                 k, rsp_valid, rsp_result, req_ready, er1);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_same_cycle_accept: got busy=%b rdy=%b expected 0 1", busy, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL second_accept: got busy=%b expected 1", busy);
    end
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    r = rsp_result; c = rsp_cout; o = rsp_ovf;
    checks++;
    if (cyc != NUM_SLICES || r !== er2) begin
      errors++;
      $display("FAIL second_rsp: got lat=%0d r=%h expected lat=%0d r=%h", cyc, r, NUM_SLICES, er2);
    end
    $display("op backpressure second AND -> res=%h cout=%b ovf=%b lat=%0d", r, c, o, cyc);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [WORD_W-1:0] r;
    logic c, o;
    req_sel = OP_ADD; req_cin = 1'b0; req_a = 16'hABCD; req_b = 16'h1111; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (alu_port_a !== 4'hB || busy !== 1'b1) begin
      errors++; $display("FAIL mid_run_idx2: got a=%h busy=%b expected b 1", alu_port_a, busy);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || rsp_result !== '0) begin
      errors++;
      $display("FAIL after_mid_reset: got vld=%b busy=%b rdy=%b r=%h expected 0 0 1 0000",
               rsp_valid, busy, req_ready, rsp_result);
    end
    run_op(OP_ADD, 1'b0, 16'h1234, 16'h1111, 0, r, c, o);
    checks++;
    if (r !== 16'h2345) begin
      errors++; $display("FAIL post_reset_add: got %h expected 2345", r);
    end
  endtask

  task automatic test_random();
    logic [WORD_W-1:0] r;
    logic c, o;
    for (int i = 0; i < 30; i++) begin
      run_op(SELECT_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             WORD_W'($urandom), WORD_W'($urandom), $urandom_range(0, 2), r, c, o);
    end
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] r;
    logic c, o;
    for (int i = 0; i < 6; i++) begin
      run_op((i % 2 == 0) ? OP_ADD : OP_A_SUB_B, 1'(i % 2),
             WORD_W'($urandom), WORD_W'($urandom), 0, r, c, o);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; req_cin = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
